// File: rtl/types_pkg.sv
// types_pkg: shared encodings and constants for the execute stage
package types_pkg;
  typedef enum logic [3:0] {
    CTL_ADD = 4'd0, CTL_SUB = 4'd1, CTL_AND = 4'd2, CTL_OR  = 4'd3, CTL_MUL = 4'd4,
    CTL_DIV = 4'd5, CTL_SLL = 4'd6, CTL_SRL = 4'd7, CTL_ROL = 4'd8, CTL_ROR = 4'd9
  } control_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE, WAIT} md_state_e;
  typedef struct packed {
    logic [1:0]  memc;
    logic        reg_wr;
    logic        r0_en;
    logic [15:0] r1_data;
    logic [7:0]  instr;
    logic [31:0] alu;
    logic        ovf;
    logic        div0;
  } ex_reg_t;
  localparam ex_reg_t BUBBLE = '0;
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed 16x16 multiply and restoring divide, one step per cycle.
// Works on magnitudes; signs are reapplied combinationally when the result is read.
module muldiv_iter
  import types_pkg::*;
#(
  parameter int MD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        up_hold,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int CW = $clog2(MD_CYCLES);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] p_q, p_d;
  logic [15:0] m_q, m_d;
  logic op_q, op_d, neg_q, neg_d, an_q, an_d;
  logic [16:0] mul_hi, div_x;
  logic [15:0] div_r;
  logic div_ge;
  always_comb begin
    mul_hi = {1'b0, p_q[31:16]} + (p_q[0] ? {1'b0, m_q} : 17'd0);
    div_x = p_q[31:15];
    div_ge = div_x >= {1'b0, m_q};
    div_r = div_ge ? 16'(div_x - {1'b0, m_q}) : div_x[15:0];
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    m_d = m_q;
    op_d = op_q;
    neg_d = neg_q;
    an_d = an_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      cnt_d = '0;
      p_d = {16'd0, a[15] ? -a : a};
      m_d = b[15] ? -b : b;
      op_d = op;
      neg_d = a[15] ^ b[15];
      an_d = a[15];
    end else if (state_q == RUN) begin
      p_d = op_q ? {div_r, p_q[14:0], div_ge} : {mul_hi, p_q[15:1]};
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CW'(MD_CYCLES - 1) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = up_hold ? WAIT : IDLE;
    end else if (state_q == WAIT && !up_hold) begin
      state_d = IDLE;
    end
  end
  assign busy = (state_q == IDLE && start) || state_q == RUN;
  assign done = state_q == DONE;
  // Remainder takes the dividend's sign, quotient the XOR of both signs.
  assign result = op_q ? {an_q ? -p_q[31:16] : p_q[31:16], neg_q ? -p_q[15:0] : p_q[15:0]}
                       : (neg_q ? -p_q : p_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_q <= '0;
      m_q <= '0;
      op_q <= 1'b0;
      neg_q <= 1'b0;
      an_q <= 1'b0;
    end else if (!halt) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      m_q <= m_d;
      op_q <= op_d;
      neg_q <= neg_d;
      an_q <= an_d;
    end
  end
endmodule

// File: rtl/stage_two.sv
// stage_two: execute stage; single-cycle ALU plus optional iterative MUL/DIV.
// The iterative unit is built only when STAGE_TWO_MULDIV_EN is defined.
module stage_two
  import types_pkg::*;
#(
  parameter int MD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        up_hold,
  input  logic [1:0]  in_memc,
  input  logic        in_reg_wr,
  input  logic [15:0] in_alu_a,
  input  logic [15:0] in_alu_b,
  input  logic [15:0] in_r1_data,
  input  logic        in_R0_en,
  input  logic [3:0]  in_alu_ctrl,
  input  logic [7:0]  in_instr,
  output logic [31:0] aluout,
  output logic        busy,
  output logic [1:0]  out_memc,
  output logic        out_reg_wr,
  output logic        out_R0_en,
  output logic [15:0] out_r1_data,
  output logic [7:0]  out_instr,
  output logic [31:0] out_alu,
  output logic        out_ovf,
  output logic        out_div0
);
  ex_reg_t out_q, out_d;
  logic [15:0] sum, dif, lo;
  logic [31:0] rol_w, ror_w, md_alu;
  logic ovf, is_md, md_div0, md_bubble;
`ifdef STAGE_TWO_MULDIV_EN
  logic is_div, b_zero, md_op, md_done;
  logic [31:0] md_result;
  assign is_div = in_alu_ctrl == CTL_DIV;
  assign b_zero = in_alu_b == 16'd0;
  assign md_div0 = is_div && b_zero;
  assign md_op = in_alu_ctrl == CTL_MUL || (is_div && !b_zero);
  // A held iterative op that is not in DONE is either running or parked in WAIT.
  assign md_bubble = md_op && !md_done;
  assign md_alu = md_div0 ? {in_alu_a, 16'hFFFF} : md_done ? md_result : 32'd0;
  muldiv_iter #(.MD_CYCLES(MD_CYCLES)) u_md (
    .clk(clk), .rst(rst), .halt(halt_sys), .up_hold(up_hold),
    .start(md_op && !halt_sys), .op(is_div), .a(in_alu_a), .b(in_alu_b),
    .busy(busy), .done(md_done), .result(md_result)
  );
`else
  logic unused_hold;
  assign unused_hold = up_hold & (MD_CYCLES == 16);
  assign md_div0 = 1'b0;
  assign md_bubble = 1'b0;
  assign md_alu = 32'd0;
  assign busy = 1'b0;
`endif
  always_comb begin
    sum = in_alu_a + in_alu_b;
    dif = in_alu_a - in_alu_b;
    rol_w = {in_alu_a, in_alu_a} << in_alu_b[3:0];
    ror_w = {in_alu_a, in_alu_a} >> in_alu_b[3:0];
    lo = in_alu_ctrl == CTL_ADD ? sum :
         in_alu_ctrl == CTL_SUB ? dif :
         in_alu_ctrl == CTL_AND ? in_alu_a & in_alu_b :
         in_alu_ctrl == CTL_OR  ? in_alu_a | in_alu_b :
         in_alu_ctrl == CTL_SLL ? in_alu_a << in_alu_b[3:0] :
         in_alu_ctrl == CTL_SRL ? in_alu_a >> in_alu_b[3:0] :
         in_alu_ctrl == CTL_ROL ? rol_w[31:16] :
         in_alu_ctrl == CTL_ROR ? ror_w[15:0] : 16'd0;
    ovf = in_alu_ctrl == CTL_ADD ? (in_alu_a[15] == in_alu_b[15] && sum[15] != in_alu_a[15]) :
          in_alu_ctrl == CTL_SUB ? (in_alu_a[15] != in_alu_b[15] && dif[15] != in_alu_a[15]) : 1'b0;
    is_md = in_alu_ctrl == CTL_MUL || in_alu_ctrl == CTL_DIV;
    aluout = is_md ? md_alu : {16'd0, lo};
    out_d = md_bubble ? BUBBLE
                      : {in_memc, in_reg_wr, in_R0_en, in_r1_data, in_instr, aluout, ovf, md_div0};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= BUBBLE;
    else if (!halt_sys) out_q <= out_d;
  end
  assign out_memc = out_q.memc;
  assign out_reg_wr = out_q.reg_wr;
  assign out_R0_en = out_q.r0_en;
  assign out_r1_data = out_q.r1_data;
  assign out_instr = out_q.instr;
  assign out_alu = out_q.alu;
  assign out_ovf = out_q.ovf;
  assign out_div0 = out_q.div0;
endmodule
